// File: rtl/img_preproc_pkg.sv
// rtl/img_preproc_pkg.sv - shared types and helpers for the image preprocessing front end
package img_preproc_pkg;

  // Deframer control states: waiting for a header, forwarding payload, dropping an oversize frame.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } deframe_state_e;

  // Default host word size; blocks built for other widths declare their own beat layout.
  localparam int unsigned DEF_WORD_BYTES = 4;

  // One output beat: payload word, byte-valid mask (LSB = byte 0), end-of-frame flag.
  typedef struct packed {
    logic [8*DEF_WORD_BYTES-1:0] data;
    logic [DEF_WORD_BYTES-1:0]   strb;
    logic                        last;
  } beat_t;

  // Byte lane byte_idx of the current word carries payload when more than byte_idx
  // bytes remain.  Evaluated per lane, so the full word is all ones when at least
  // a word's worth remains and the low (remaining) lanes otherwise.
  function automatic logic strb_bit_from_remaining(input logic [63:0] remaining,
                                                   input int          byte_idx);
    return remaining > 64'(byte_idx);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - two-entry skid buffer with registered outputs
module stream_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i
);

  // out_* is the head entry driving the consumer; skid_* catches one extra word
  // so push_ready never depends combinationally on pop_ready.
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             push;
  logic             pop;

  assign push_ready_o = !skid_valid_q;
  assign pop_data_o   = out_data_q;
  assign pop_valid_o  = out_valid_q;

  // Next-state of both entries for every push/pop combination.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    push         = push_valid_i && !skid_valid_q;
    pop          = out_valid_q && pop_ready_i;
    if (pop) begin
      if (skid_valid_q) begin
        // Full: no push possible; the skid entry moves up to the head.
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_data_d  = push_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid_q) begin
        out_data_d  = push_data_i;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = push_data_i;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Entry registers; reset empties the buffer and clears the visible beat.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/img_stream_deframer.sv
// rtl/img_stream_deframer.sv - length-prefixed word stream to strobed payload beats
module img_stream_deframer
  import img_preproc_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned MAX_BYTES  = 1048576,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [8*WORD_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    upstream_stall,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]   out_strb,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    downstream_stall,
  output logic                    core_reset,
  output logic                    err_oversize,
  output logic [LEN_W-1:0]        bytes_remaining,
  output logic [FCNT_W-1:0]       frame_count
);

  localparam int unsigned         DATA_W = 8 * WORD_BYTES;
  localparam int unsigned         BEAT_W = DATA_W + WORD_BYTES + 1;
  localparam logic [LEN_W-1:0]    WB_L   = LEN_W'(WORD_BYTES);

  if (WORD_BYTES == 0 || (WORD_BYTES & (WORD_BYTES - 1)) != 0) begin : g_bad_word_bytes
    $error("WORD_BYTES must be a nonzero power of two");
  end
  if (LEN_W > DATA_W || LEN_W > 64) begin : g_bad_len_w
    $error("LEN_W must fit in one data word and in 64 bits");
  end

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [WORD_BYTES-1:0] strb;
    logic                  last;
  } deframe_beat_t;

  deframe_state_e    state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              core_reset_q, core_reset_d;
  logic              err_oversize_q, err_oversize_d;
  logic [FCNT_W-1:0] frame_count_q;

  logic [LEN_W-1:0]  hdr;
  logic [LEN_W-1:0]  rem_dec;
  logic              is_last;
  logic              in_fire;
  logic              push_valid;
  logic              push_ready;
  logic              pop_valid;
  deframe_beat_t     push_beat;
  deframe_beat_t     pop_beat;
  logic [BEAT_W-1:0] pop_bits;

  // Strobe and beat for the word currently presented, built from the bytes still owed.
  always_comb begin
    push_beat.data = in_data;
    push_beat.strb = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      push_beat.strb[i] = strb_bit_from_remaining(64'(rem_q), i);
    end
    push_beat.last = is_last;
  end

  // Header decode and payload accounting: next state, remaining count and status pulses.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    core_reset_d   = 1'b0;
    err_oversize_d = 1'b0;
    push_valid     = 1'b0;
    hdr            = in_data[LEN_W-1:0];
    rem_dec        = (rem_q >= WB_L) ? (rem_q - WB_L) : '0;
    is_last        = (rem_q <= WB_L);
    upstream_stall = (state_q == PAYLOAD) ? !push_ready : 1'b0;
    in_fire        = in_valid && !upstream_stall;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (hdr == '0) begin
            core_reset_d = 1'b1;
          end else if (64'(hdr) > 64'(MAX_BYTES)) begin
            err_oversize_d = 1'b1;
            rem_d          = hdr;
            state_d        = DISCARD;
          end else begin
            rem_d   = hdr;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_fire) begin
          push_valid = 1'b1;
          rem_d      = rem_dec;
          if (is_last) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (in_fire) begin
          rem_d = rem_dec;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; a system reset returns to header-hunting without a core_reset pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      core_reset_q   <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      core_reset_q   <= core_reset_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  stream_skid_buf #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clock_i      (clock),
    .reset_i      (reset),
    .push_data_i  (push_beat),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .pop_data_o   (pop_bits),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (!downstream_stall)
  );

  assign pop_beat = deframe_beat_t'(pop_bits);

  // Count frames whose final beat has been handed to the consumer; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (pop_valid && !downstream_stall && pop_beat.last) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign out_data        = pop_beat.data;
  assign out_strb        = pop_beat.strb;
  assign out_last        = pop_beat.last;
  assign out_valid       = pop_valid;
  assign core_reset      = core_reset_q;
  assign err_oversize    = err_oversize_q;
  assign bytes_remaining = rem_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_img_stream_deframer.sv
// tb/tb_img_stream_deframer.sv - directed self-checking bench for img_stream_deframer
module tb_img_stream_deframer;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        upstream_stall;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last;
  logic        out_valid;
  logic        downstream_stall;
  logic        core_reset;
  logic        err_oversize;
  logic [31:0] bytes_remaining;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  bit          q_last[$];
  int          core_reset_cnt = 0;
  int          err_cnt = 0;

  img_stream_deframer #(
    .WORD_BYTES(4),
    .LEN_W(32),
    .MAX_BYTES(16),
    .FCNT_W(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .upstream_stall   (upstream_stall),
    .out_data         (out_data),
    .out_strb         (out_strb),
    .out_last         (out_last),
    .out_valid        (out_valid),
    .downstream_stall (downstream_stall),
    .core_reset       (core_reset),
    .err_oversize     (err_oversize),
    .bytes_remaining  (bytes_remaining),
    .frame_count      (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record beats that will transfer at the next rising edge, plus status pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && !downstream_stall) begin
        q_data.push_back(out_data);
        q_strb.push_back(out_strb);
        q_last.push_back(out_last);
      end
      if (core_reset) core_reset_cnt++;
      if (err_oversize) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] w, output int waited);
    bit done;
    done    = 1'b0;
    waited  = 0;
    in_data = w;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      if (!upstream_stall) done = 1'b1;
      else waited++;
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: word %h still stalled after %0d cycles, required acceptance", w, waited);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int c = 0; c < 30 && out_valid; c++) step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = '0;
    downstream_stall = 1'b0;
    step();
    step();
    reset = 1'b0;
    q_data.delete();
    q_strb.delete();
    q_last.delete();
    core_reset_cnt = 0;
    err_cnt        = 0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    in_valid         = 1'b1;
    in_data          = 32'd5;
    downstream_stall = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid, out_last, out_strb, core_reset, err_oversize, upstream_stall} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0", {out_valid, out_last, out_strb, core_reset, err_oversize, upstream_stall});
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", out_data);
    end
    checks++;
    if (bytes_remaining !== 32'd0) begin
      errors++;
      $display("FAIL reset_remaining: got %0d, required 0", bytes_remaining);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d, required 0", frame_count);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d[3];
    logic [3:0]  exp_s[3];
    bit          exp_l[3];
    int          w;
    exp_d = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    exp_s = '{4'b1111, 4'b1111, 4'b0011};
    exp_l = '{1'b0, 1'b0, 1'b1};
    do_reset();
    send(32'd10, w);
    checks++;
    if (bytes_remaining !== 32'd10) begin
      errors++;
      $display("FAIL basic_hdr_remaining: got %0d, required 10", bytes_remaining);
    end
    send(exp_d[0], w);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d[0]) begin
      errors++;
      $display("FAIL basic_latency: valid=%b data=%h, required 1 %h", out_valid, out_data, exp_d[0]);
    end
    checks++;
    if (bytes_remaining !== 32'd6) begin
      errors++;
      $display("FAIL basic_remaining: got %0d, required 6", bytes_remaining);
    end
    send(exp_d[1], w);
    send(exp_d[2], w);
    drain();
    checks++;
    if (q_data.size() != 3) begin
      errors++;
      $display("FAIL basic_count: got %0d beats, required 3", q_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_data[i] !== exp_d[i] || q_strb[i] !== exp_s[i] || q_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h/%b/%b, required %h/%b/%b", i, q_data[i], q_strb[i], q_last[i], exp_d[i], exp_s[i], exp_l[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd1 || bytes_remaining !== 32'd0) begin
      errors++;
      $display("FAIL basic_end: frame_count=%0d remaining=%0d, required 1 0", frame_count, bytes_remaining);
    end
  endtask

  task automatic test_zero_header();
    int w;
    do_reset();
    send(32'd0, w);
    in_valid = 1'b0;
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse: core_reset=%b, required 1", core_reset);
    end
    step();
    checks++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_end: core_reset=%b, required 0", core_reset);
    end
    step();
    checks++;
    if (core_reset_cnt != 1 || q_data.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_quiet: pulses=%0d beats=%0d valid=%b, required 1 0 0", core_reset_cnt, q_data.size(), out_valid);
    end
    send(32'd4, w);
    send(32'hDEADBEEF, w);
    drain();
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'hDEADBEEF || q_strb[0] !== 4'hF || q_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_next_frame: beats=%0d first=%h/%b/%b, required 1 deadbeef/1111/1", q_data.size(), q_data[0], q_strb[0], q_last[0]);
    end
  endtask

  task automatic test_oversize();
    int w;
    int stalled;
    do_reset();
    send(32'd20, w);
    checks++;
    if (err_oversize !== 1'b1 || bytes_remaining !== 32'd20) begin
      errors++;
      $display("FAIL over_pulse: err=%b remaining=%0d, required 1 20", err_oversize, bytes_remaining);
    end
    stalled = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h1000 + i, w);
      stalled += w;
    end
    in_valid = 1'b0;
    checks++;
    if (stalled != 0) begin
      errors++;
      $display("FAIL over_stall: stalled %0d cycles, required 0", stalled);
    end
    checks++;
    if (bytes_remaining !== 32'd0) begin
      errors++;
      $display("FAIL over_remaining: got %0d, required 0", bytes_remaining);
    end
    step();
    checks++;
    if (err_cnt != 1 || q_data.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL over_quiet: pulses=%0d beats=%0d valid=%b, required 1 0 0", err_cnt, q_data.size(), out_valid);
    end
    send(32'd4, w);
    send(32'hCAFEF00D, w);
    drain();
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'hCAFEF00D || q_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL over_back_idle: beats=%0d first=%h last=%b, required 1 cafef00d 1", q_data.size(), q_data[0], q_last[0]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_d[4];
    int          w;
    exp_d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    do_reset();
    downstream_stall = 1'b1;
    send(32'd16, w);
    send(exp_d[0], w);
    send(exp_d[1], w);
    checks++;
    if (upstream_stall !== 1'b1 || out_data !== exp_d[0]) begin
      errors++;
      $display("FAIL stall_full: stall=%b data=%h, required 1 %h", upstream_stall, out_data, exp_d[0]);
    end
    in_data = exp_d[2];
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (upstream_stall !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_d[0] || q_data.size() != 0) begin
      errors++;
      $display("FAIL stall_hold: stall=%b valid=%b data=%h beats=%0d, required 1 1 %h 0", upstream_stall, out_valid, out_data, q_data.size(), exp_d[0]);
    end
    downstream_stall = 1'b0;
    send(exp_d[2], w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL stall_release: waited %0d cycles, required 1", w);
    end
    send(exp_d[3], w);
    drain();
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, required 4", q_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp_d[i] || q_strb[i] !== 4'hF || q_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h/%b/%b, required %h/1111/%b", i, q_data[i], q_strb[i], q_last[i], exp_d[i], (i == 3));
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_frames: got %0d, required 1", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[3];
    bit          exp_l[3];
    int          w;
    int          stalled;
    exp_d = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    exp_l = '{1'b1, 1'b0, 1'b1};
    do_reset();
    stalled = 0;
    send(32'd4, w);    stalled += w;
    send(exp_d[0], w); stalled += w;
    send(32'd8, w);    stalled += w;
    send(exp_d[1], w); stalled += w;
    send(exp_d[2], w); stalled += w;
    drain();
    checks++;
    if (stalled != 0 || q_data.size() != 3) begin
      errors++;
      $display("FAIL b2b_flow: stalled=%0d beats=%0d, required 0 3", stalled, q_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_data[i] !== exp_d[i] || q_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h/%b, required %h/%b", i, q_data[i], q_last[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d, required 2", frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    do_reset();
    send(32'd16, w);
    send(32'h01010101, w);
    send(32'h02020202, w);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || bytes_remaining !== 32'd0 || upstream_stall !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: valid=%b remaining=%0d stall=%b core_reset=%b, required 0 0 0 0", out_valid, bytes_remaining, upstream_stall, core_reset);
    end
    q_data.delete();
    q_strb.delete();
    q_last.delete();
    send(32'd4, w);
    send(32'h5A5AA5A5, w);
    drain();
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'h5A5AA5A5 || q_strb[0] !== 4'hF || q_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_frame: beats=%0d first=%h/%b/%b, required 1 5a5aa5a5/1111/1", q_data.size(), q_data[0], q_strb[0], q_last[0]);
    end
    checks++;
    if (frame_count !== 16'd1 || core_reset_cnt != 0) begin
      errors++;
      $display("FAIL midreset_counts: frame_count=%0d core_reset pulses=%0d, required 1 0", frame_count, core_reset_cnt);
    end
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = '0;
    downstream_stall = 1'b0;
    test_reset();
    test_basic();
    test_zero_header();
    test_oversize();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_stream_deframer.md
Name: img_stream_deframer

Overview:
Parametrised front end for the image preprocessing path. It accepts a length-prefixed byte stream (one header word giving the payload byte count, then payload words) and emits payload beats with a byte strobe and a last flag. It applies proper valid/stall handshakes on both sides through a 2-entry skid buffer, and rejects empty or oversize frames. It sits between the host word stream and the JPEG decode core.

Parameters:
WORD_BYTES, 4, bytes per data word; must be a power of 2 and at least 1
LEN_W, 32, width of the header length field; must satisfy LEN_W <= 8*WORD_BYTES
MAX_BYTES, 1048576, largest accepted payload length in bytes
FCNT_W, 16, width of the frame counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  8*WORD_BYTES  header or payload word
in_valid  in  1  in_data is valid
upstream_stall  out  1  block cannot accept in_data this cycle
out_data  out  8*WORD_BYTES  payload word; byte 0 is in the LSBs
out_strb  out  WORD_BYTES  valid-byte mask, LSB-first
out_last  out  1  final beat of the frame
out_valid  out  1  out_data, out_strb and out_last are valid
downstream_stall  in  1  consumer cannot accept a beat
core_reset  out  1  one-cycle pulse on a zero-length header
err_oversize  out  1  one-cycle pulse on a header greater than MAX_BYTES
bytes_remaining  out  LEN_W  payload bytes still to be accepted
frame_count  out  FCNT_W  number of frames whose last beat has been accepted

Behaviour:
- Handshakes
  - An input transfer occurs when in_valid && !upstream_stall.
  - An output transfer occurs when out_valid && !downstream_stall.
  - out_* stay stable while out_valid && downstream_stall.
- Reset values: every output is 0; the FSM is in IDLE; the skid buffer is empty; the counters are 0.
- State IDLE (waiting for a header)
  - upstream_stall = 0.
  - The header L is in_data[LEN_W-1:0].
  - L == 0: pulse core_reset for the next cycle; stay in IDLE.
  - L > MAX_BYTES: pulse err_oversize for the next cycle; bytes_remaining <= L; go to DISCARD.
  - Otherwise: bytes_remaining <= L; go to PAYLOAD.
- State PAYLOAD
  - upstream_stall = skid buffer full.
  - Each accepted word is pushed to the buffer with:
    - strobe = all ones if bytes_remaining >= WORD_BYTES, else (1 << bytes_remaining) - 1;
    - last = (bytes_remaining <= WORD_BYTES).
  - bytes_remaining saturates at 0 when decremented by WORD_BYTES.
  - On accepting the last word, go to IDLE. The next word is a header, even if the tail is still buffered.
- State DISCARD
  - upstream_stall = 0.
  - Accepted words are dropped and decrement bytes_remaining the same way.
  - On the last word, go to IDLE.
  - Nothing is pushed to the buffer.
- Skid buffer
  - 2 entries, registered outputs, zero bubbles at full throughput.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Latency from input transfer to out_valid is 1 cycle when the buffer is empty.
- frame_count increments on each output transfer with out_last = 1 and wraps at 2^FCNT_W.
- Reset mid-frame:
  - The buffer is flushed and out_valid = 0 on the next cycle.
  - The FSM goes to IDLE and the next input word is treated as a header.
  - No core_reset pulse is generated (the system reset covers the core).
- No gated clocks; every register is on the clock port.

Decomposition:
- Package img_preproc_pkg:
  - deframe_state_e enum {IDLE, PAYLOAD, DISCARD};
  - the beat struct {data, strb, last};
  - a strobe-from-remaining function.
- Sub-module stream_skid_buf (2-entry, parametrised on payload width) holds the output buffering and is reusable on the pixel output side.

Test Plan:
- WORD_BYTES=4, header 10, three words 0x03020100, 0x07060504, 0x0B0A0908, no stall -> three beats with strb 1111, 1111, 0011; out_last on beat 3 only; frame_count = 1.
- Header 0 -> core_reset high for exactly 1 cycle; no out_valid; the next word is accepted as a header.
- MAX_BYTES=16, header 20, five payload words -> err_oversize pulses once; all five words are accepted with upstream_stall = 0; no out_valid; back in IDLE.
- Header 16, four words streamed with downstream_stall held high for 6 cycles -> upstream_stall rises after 2 words are buffered; after release all 4 beats emerge in order, nothing lost or duplicated.
- Back-to-back frames (header 4 + 1 word, then header 8 + 2 words) with no idle cycles -> 3 beats, out_last on beats 1 and 3, frame_count = 2.
- reset asserted after 2 of 4 payload words -> out_valid = 0 next cycle; the next word, value 4, is taken as a header, and a following 1-word frame is output correctly.
